// File: rtl/period_capture.sv
// Measures the period and high time of an asynchronous toggling input in clk cycles.
// A capture waits in period/high_time until acknowledged; a capture that arrives while one is still pending is dropped.
module period_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             ack,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                 state, state_d;
  logic [WIDTH-1:0]       cnt, cnt_d;
  logic [WIDTH-1:0]       hcap, hcap_d;
  logic [WIDTH-1:0]       period_d, high_d;
  logic                   valid_d, overrun_d, timeout_d;
  logic                   capture;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic                   sync_s, rise, fall;

  // The synchronizer keeps running while en is low, so that no false edge appears when measurement resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist;
  assign fall   = ~sync_s & hist;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hcap_d    = hcap;
    period_d  = period;
    high_d    = high_time;
    valid_d   = valid;
    overrun_d = overrun;
    timeout_d = timeout;
    capture   = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcap_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          hcap_d  = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            hcap_d  = '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            capture = 1'b1;
            cnt_d   = CNT_ONE;
            hcap_d  = '0;
          end else if (cnt == CNT_MAX) begin
            // The counter is saturated with no edge in sight: abandon this period and re-arm.
            timeout_d = 1'b1;
            state_d   = ARM;
            cnt_d     = '0;
            hcap_d    = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
            if (fall) hcap_d = cnt;
          end
        end
        default: state_d = IDLE;
      endcase

      // An ack arriving with a capture frees the slot in the same cycle.
      if (capture) begin
        if (!valid || ack) begin
          period_d = cnt;
          high_d   = hcap;
          valid_d  = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (ack && valid) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcap      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hcap      <= hcap_d;
      period    <= period_d;
      high_time <= high_d;
      valid     <= valid_d;
      overrun   <= overrun_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_period_capture.sv
// Directed and randomized bench for period_capture. Expected captures are derived from the high and low durations driven on sig_in.
module tb_period_capture;

  localparam int W  = 16;
  localparam int NR = 10;

  logic         clk, rst, en, sig_in, ack;
  logic [W-1:0] period, high_time;
  logic         valid, overrun, timeout;

  int total = 0;
  int bad   = 0;
  int hv[NR];
  int lv[NR];
  int rgot;

  period_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .ack       (ack),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; sig_in holds v across the next n rising edges.
  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; sig_in = 1'b0; ack = 1'b0;
    #1;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // sig_in toggling every clk: period 2, high 1
    en = 1'b1;
    hold(1'b0, 2);
    for (int i = 0; i < 20 && valid !== 1'b1; i++) hold(i % 2 == 0, 1);
    chk("div2_valid", valid, 1);
    chk("div2_period", period, 2);
    chk("div2_high", high_time, 1);
    repeat (6) hold(~sig_in, 1);
    chk("div2_overrun", overrun, 1);
    chk("div2_hold_period", period, 2);

    // en low clears the flags and keeps the last result
    sig_in = 1'b0;
    en = 1'b0;
    hold(1'b0, 1);
    chk("endrop_valid", valid, 0);
    chk("endrop_overrun", overrun, 0);
    chk("endrop_timeout", timeout, 0);
    chk("endrop_period", period, 2);
    en = 1'b1;
    hold(1'b0, 3);

    // 3 high / 5 low, never acknowledged: first capture held, overrun raised
    repeat (4) begin
      hold(1'b1, 3);
      hold(1'b0, 5);
    end
    hold(1'b1, 4);
    chk("noack_valid", valid, 1);
    chk("noack_period", period, 8);
    chk("noack_high", high_time, 3);
    chk("noack_overrun", overrun, 1);

    // ack coincident with a capture while valid: new values load, no overrun
    en = 1'b0;
    hold(1'b0, 2);
    en = 1'b1;
    hold(1'b0, 2);
    fork
      begin
        hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 2); hold(1'b0, 4); hold(1'b1, 4);
      end
      begin
        for (int i = 0; i < 60 && valid !== 1'b1; i++) @(negedge clk);
        chk("same_ack_wait", valid, 1);
        repeat (5) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("same_ack_valid", valid, 1);
        chk("same_ack_period", period, 6);
        chk("same_ack_high", high_time, 2);
        chk("same_ack_overrun", overrun, 0);
      end
    join
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_clears_valid", valid, 0);
    @(negedge clk);
    chk("ack_idle_valid", valid, 0);

    // random high/low durations, every capture acknowledged
    hold(1'b0, 3);
    en = 1'b0;
    hold(1'b0, 1);
    en = 1'b1;
    hold(1'b0, 2);
    for (int k = 0; k < NR; k++) begin
      hv[k] = $urandom_range(1, 20);
      lv[k] = $urandom_range(1, 20);
    end
    rgot = 0;
    fork
      begin
        hold(1'b0, 2);
        for (int k = 0; k < NR; k++) begin
          hold(1'b1, hv[k]);
          hold(1'b0, lv[k]);
        end
        hold(1'b1, 6);
      end
      begin
        for (int c = 0; c < 2000 && rgot < NR; c++) begin
          @(negedge clk);
          if (valid === 1'b1) begin
            chk("rnd_period", period, hv[rgot] + lv[rgot]);
            chk("rnd_high", high_time, hv[rgot]);
            rgot++;
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
          end
        end
      end
    join
    chk("rnd_count", rgot, NR);
    chk("rnd_overrun", overrun, 0);

    // reset in the middle of a period
    hold(1'b0, 3);
    hold(1'b1, 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_period", period, 0);
    chk("midrst_high", high_time, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 3);
    hold(1'b1, 10);
    chk("postrst_first_rise", valid, 0);
    hold(1'b0, 4);
    hold(1'b1, 4);
    chk("postrst_valid", valid, 1);
    chk("postrst_period", period, 14);
    chk("postrst_high", high_time, 10);

    // armed, then low for the whole counter range: timeout and re-arm
    en = 1'b0;
    hold(1'b0, 2);
    en = 1'b1;
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 65400);
    chk("to_early", timeout, 0);
    hold(1'b0, 200);
    chk("to_set", timeout, 1);
    chk("to_valid", valid, 0);
    hold(1'b1, 4);
    hold(1'b0, 6);
    hold(1'b1, 5);
    chk("to_recap_valid", valid, 1);
    chk("to_recap_period", period, 10);
    chk("to_recap_high", high_time, 4);
    chk("to_sticky", timeout, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_capture.md
PERIOD_CAPTURE -- requirements
Module: period_capture

Interface
REQ-001 Parameter WIDTH, default 16, width of cycle counter and capture registers.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth (minimum 2).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  measurement enable; low forces IDLE.
REQ-006 sig_in  input  1  asynchronous toggling input (e.g. a timer T flip-flop output) to be measured.
REQ-007 ack  input  1  consumer acknowledge of a capture.
REQ-008 period  output  WIDTH  clk cycles between the last two detected rising edges.
REQ-009 high_time  output  WIDTH  clk cycles sig was high within that period.
REQ-010 valid  output  1  capture pending; period/high_time hold a new result.
REQ-011 overrun  output  1  sticky: a capture was dropped because valid was unacknowledged.
REQ-012 timeout  output  1  sticky: counter saturated without a rising edge.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops, then one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-014 With SYNC_STAGES=2, a sig_in transition stable before clk edge N SHALL produce a rise/fall pulse in cycle N+2, one cycle wide.
REQ-015 State machine SHALL have states IDLE, ARM, MEASURE.
REQ-016 IDLE: en=1 -> ARM next cycle; cnt held at 0.
REQ-017 ARM: rise -> MEASURE with cnt<=1; no capture on this first edge; fall ignored.
REQ-018 MEASURE, no edge: cnt<=cnt+1, saturating at 2^WIDTH-1.
REQ-019 MEASURE, fall: hcap<=cnt; cnt still increments.
REQ-020 MEASURE, rise: capture event -- period<=cnt, high_time<=hcap, cnt<=1, hcap<=0, remain MEASURE.
REQ-021 A rise with no fall since previous rise (sig stuck high between) SHALL capture high_time=0.
REQ-022 cnt reaching 2^WIDTH-1 in MEASURE without rise: timeout<=1, state->ARM, cnt<=0; period/high_time/valid unchanged.
REQ-023 Capture with valid=0 or ack=1 same cycle: registers load, valid<=1.
REQ-024 Capture with valid=1 and ack=0: registers keep old values, valid stays 1, overrun<=1.
REQ-025 ack=1 with valid=1 and no capture: valid<=0 next cycle; ack with valid=0 has no effect.
REQ-026 en=0 in any state: next cycle state=IDLE, cnt=0, hcap=0, valid=0, overrun=0, timeout=0; period/high_time retained; synchronizer keeps running.
REQ-027 overrun and timeout SHALL clear only via rst or en=0.
REQ-028 All arithmetic unsigned WIDTH bits; no wrap of cnt permitted.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, cnt=0, hcap=0, period=0, high_time=0, valid=0, overrun=0, timeout=0, synchronizer and history flops=0.
REQ-030 rst asserted mid-MEASURE SHALL discard partial count; after release with en=1, first rise only arms (no capture).
REQ-031 rst deassertion SHALL be synchronized externally; block takes no action until first clk edge after release.

Verification (WIDTH=16, SYNC_STAGES=2)
REQ-032 sig_in toggled every clk (divide-by-2 T flip-flop), en=1 -> second detected rise gives period=2, high_time=1, valid=1.
REQ-033 sig_in high 3 cycles, low 5, repeating -> period=8, high_time=3 each capture; ack each capture -> overrun stays 0.
REQ-034 Same stimulus, ack never asserted -> first capture held (8/3), valid=1, overrun=1 after next rise.
REQ-035 After arming, sig_in held low 65535 cycles -> timeout=1, state ARM, valid unchanged; next two rises produce a fresh capture.
REQ-036 ack asserted in same cycle as a capture with valid=1 -> new values loaded, valid stays 1, overrun=0.
REQ-037 rst pulsed mid-period, then en low/high toggling -> all outputs 0 after rst, flags cleared on en=0, first post-release rise produces no capture.
